scirc_modn_bh: RTL

//   Parametrised successor to the 4-state, x-driven counter FSM.
//   N-state machine (N <= 2**W) advanced by x_i, counting up or down.

---
 rtl/scirc_modn_bh.sv | 110 +++++++++++
 1 files changed

// File: rtl/scirc_modn_bh.sv
// scirc_modn_bh: N-state up/down counter FSM advanced by x_i.
// - Wrap or saturate at the ends is fixed when the design is elaborated.
// - Adds a synchronous clamped load and a combinational terminal-count flag.
// - Produces a registered one-cycle pulse in the cycle after a wrap.
// - Encodings N..2**W-1 cannot be reached normally. If one ever shows up,
//   it is pulled back to state 0 on the next edge.
module scirc_modn_bh #(
  parameter int W        = 2,
  parameter int N        = 4,
  parameter int SATURATE = 0,
  parameter int INIT     = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         x_i,
  input  logic         dir_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  output logic [W-1:0] y_out_o,
  output logic         tc_o,
  output logic         wrap_o
);

  // Reject parameter sets that would leave the state space ill-defined.
  if (N < 2 || N > (1 << W) || INIT < 0 || INIT >= N) begin : g_bad_params
    $error("scirc_modn_bh: illegal parameters W=%0d N=%0d INIT=%0d", W, N, INIT);
  end

  // The highest legal state and the reset state, at state width.
  localparam logic [W-1:0] LAST   = W'(N - 1);
  localparam logic [W-1:0] FIRST  = '0;
  localparam logic [W-1:0] INIT_V = W'(INIT);

  // These constants are one bit wider than the state.
  // That keeps the range compares meaningful even when N == 2**W.
  localparam logic [W:0] LAST_EXT = (W + 1)'(N - 1);
  localparam logic [W:0] N_EXT    = (W + 1)'(N);

  logic [W-1:0] state_q, state_d;
  logic         wrap_q,  wrap_d;
  logic [W-1:0] ld_clamped;
  logic         illegal_state;
  logic         at_last;
  logic         at_first;

  // Qualify the current state and clamp the requested load value.
  always_comb begin
    at_last       = (state_q == LAST);
    at_first      = (state_q == FIRST);
    illegal_state = ({1'b0, state_q} >= N_EXT);
    ld_clamped    = ld_val_i;
    if ({1'b0, ld_val_i} > LAST_EXT) begin
      ld_clamped = LAST;
    end
  end

  // Next-state and wrap-pulse logic.
  // Priority is load first, then illegal-state recovery, then step, then hold.
  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;
    if (ld_i) begin
      state_d = ld_clamped;
    end else if (illegal_state) begin
      state_d = FIRST;
    end else if (x_i) begin
      if (dir_i) begin
        if (!at_last) begin
          state_d = state_q + W'(1);
        end else if (SATURATE != 0) begin
          state_d = LAST;
        end else begin
          state_d = FIRST;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!at_first) begin
          state_d = state_q - W'(1);
        end else if (SATURATE != 0) begin
          state_d = FIRST;
        end else begin
          state_d = LAST;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  // State and wrap-pulse registers.
  // The reset is asynchronous, so the outputs change without waiting for a clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= INIT_V;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
    end
  end

  // Terminal count is the limit for the direction currently requested.
  // It is valid during reset as well.
  always_comb begin
    tc_o = dir_i ? at_last : at_first;
  end

  assign y_out_o = state_q;
  assign wrap_o  = wrap_q;

endmodule
